// File: rtl/ahb_lite_master.sv
// AHB-Lite master bridging a valid/ready command port to a pipelined single-transfer bus.
// An address-phase register overlaps with a data-phase register so that one transfer completes per cycle.
module ahb_lite_master (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [3:0]  cmd_prot,
  input  logic [63:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [63:0] HWDATA,
  input  logic [63:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic        aph_valid;
  logic        aph_write;
  logic [31:0] aph_addr;
  logic [2:0]  aph_size;
  logic [3:0]  aph_prot;
  logic [63:0] aph_wdata;
  logic        dph_valid;
  logic        dph_write;
  logic [63:0] hwdata_q;
  logic        err_cancel;

  logic cmd_accept;
  logic aph_done;
  logic dph_done;

  assign cmd_ready  = HRESETn & ~err_cancel & (~aph_valid | HREADY);
  assign cmd_accept = cmd_valid & cmd_ready;
  // err_cancel blocks the pending address phase so the slave never sees it during an error response
  assign aph_done   = aph_valid & HREADY & ~err_cancel;
  assign dph_done   = dph_valid & HREADY;

  assign HTRANS    = (aph_valid && !err_cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = aph_addr;
  assign HWRITE    = aph_write;
  assign HSIZE     = aph_size;
  assign HPROT     = aph_prot;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = hwdata_q;

  // Address phase stage
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      aph_valid <= 1'b0;
      aph_write <= 1'b0;
      aph_addr  <= '0;
      aph_size  <= '0;
      aph_prot  <= '0;
      aph_wdata <= '0;
    end else if (cmd_accept) begin
      aph_valid <= 1'b1;
      aph_write <= cmd_write;
      aph_addr  <= cmd_addr;
      aph_size  <= cmd_size;
      aph_prot  <= cmd_prot;
      aph_wdata <= cmd_wdata;
    end else if (aph_done) begin
      aph_valid <= 1'b0;
    end
  end

  // Data phase stage
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dph_valid <= 1'b0;
      dph_write <= 1'b0;
      hwdata_q  <= '0;
    end else if (aph_done) begin
      dph_valid <= 1'b1;
      dph_write <= aph_write;
      if (aph_write) hwdata_q <= aph_wdata;
    end else if (dph_done) begin
      dph_valid <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_cancel <= 1'b0;
    end else if (err_cancel && HREADY) begin
      err_cancel <= 1'b0;
    end else if (dph_valid && HRESP && !HREADY) begin
      err_cancel <= 1'b1;
    end
  end

  // Response stage
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= dph_done;
      if (dph_done) begin
        rsp_rdata <= dph_write ? 64'd0 : HRDATA;
        rsp_err   <= HRESP;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: reset, single write, back-to-back reads, wait states, error cancel, mid-transfer reset.
module tb_ahb_lite_master;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [3:0]  cmd_prot;
  logic [63:0] cmd_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int n_checks = 0;
  int n_pass   = 0;

  ahb_lite_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_prot(cmd_prot), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  task automatic set_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [3:0] prot, input logic [63:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_prot  = prot;
    cmd_wdata = wdata;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_prot = '0; cmd_wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    #1;
    n_checks++; if (HTRANS !== 2'b00) $display("FAIL rst_htrans: got %h want 0", HTRANS); else n_pass++;
    n_checks++; if (HADDR !== 32'h0) $display("FAIL rst_haddr: got %h want 0", HADDR); else n_pass++;
    n_checks++; if (HWDATA !== 64'h0) $display("FAIL rst_hwdata: got %h want 0", HWDATA); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); else n_pass++;
    n_checks++; if ({rsp_valid, rsp_err} !== 2'b00) $display("FAIL rst_rsp: got %b want 00", {rsp_valid, rsp_err}); else n_pass++;
    n_checks++; if ({HWRITE, HSIZE, HPROT} !== 8'h0) $display("FAIL rst_ctrl: got %h want 0", {HWRITE, HSIZE, HPROT}); else n_pass++;
    tick(); tick();
    HRESETn = 1'b1;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", cmd_ready); else n_pass++;
    n_checks++; if ({HBURST, HMASTLOCK} !== 4'h0) $display("FAIL const_burst_lock: got %h want 0", {HBURST, HMASTLOCK}); else n_pass++;
  endtask

  task automatic test_single_write();
    set_cmd(1'b1, 32'h1000, 3'd2, 4'b0011, 64'h0000_0000_DEAD_BEEF);
    #1;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL wr_ready: got %b want 1", cmd_ready); else n_pass++;
    tick();
    cmd_valid = 1'b0;
    n_checks++; if (HTRANS !== 2'b10) $display("FAIL wr_htrans: got %h want 2", HTRANS); else n_pass++;
    n_checks++; if (HADDR !== 32'h1000) $display("FAIL wr_haddr: got %h want 1000", HADDR); else n_pass++;
    n_checks++; if ({HWRITE, HSIZE, HPROT} !== {1'b1, 3'd2, 4'b0011}) $display("FAIL wr_ctrl: got %h want %h", {HWRITE, HSIZE, HPROT}, {1'b1, 3'd2, 4'b0011}); else n_pass++;
    tick();
    n_checks++; if (HTRANS !== 2'b00) $display("FAIL wr_idle: got %h want 0", HTRANS); else n_pass++;
    n_checks++; if (HWDATA !== 64'hDEAD_BEEF) $display("FAIL wr_hwdata: got %h want deadbeef", HWDATA); else n_pass++;
    n_checks++; if (HADDR !== 32'h1000) $display("FAIL wr_haddr_hold: got %h want 1000", HADDR); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL wr_rsp_early: got %b want 0", rsp_valid); else n_pass++;
    tick();
    n_checks++; if ({rsp_valid, rsp_err} !== 2'b10) $display("FAIL wr_rsp: got %b want 10", {rsp_valid, rsp_err}); else n_pass++;
    n_checks++; if (rsp_rdata !== 64'h0) $display("FAIL wr_rdata: got %h want 0", rsp_rdata); else n_pass++;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    set_cmd(1'b0, 32'h0, 3'd3, 4'b0001, 64'h0);
    tick();
    set_cmd(1'b0, 32'h8, 3'd3, 4'b0001, 64'h0);
    #1;
    n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0) $display("FAIL b2b_first: got %h/%h want 2/0", HTRANS, HADDR); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", cmd_ready); else n_pass++;
    tick();
    cmd_valid = 1'b0;
    HRDATA = 64'h11;
    n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h8) $display("FAIL b2b_second: got %h/%h want 2/8", HTRANS, HADDR); else n_pass++;
    tick();
    HRDATA = 64'h22;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h11) $display("FAIL b2b_rsp0: got %b/%h want 1/11", rsp_valid, rsp_rdata); else n_pass++;
    n_checks++; if (HTRANS !== 2'b00) $display("FAIL b2b_idle: got %h want 0", HTRANS); else n_pass++;
    tick();
    HRDATA = 64'h0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h22) $display("FAIL b2b_rsp1: got %b/%h want 1/22", rsp_valid, rsp_rdata); else n_pass++;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL b2b_rsp_end: got %b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_wait_states();
    set_cmd(1'b1, 32'h40, 3'd3, 4'b0011, 64'h0123_4567_89AB_CDEF);
    tick();
    set_cmd(1'b0, 32'h48, 3'd3, 4'b0001, 64'h0);
    tick();
    cmd_valid = 1'b0;
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h48 || HWRITE !== 1'b0) $display("FAIL ws_aph_hold%0d: got %h/%h/%b want 2/48/0", i, HTRANS, HADDR, HWRITE); else n_pass++;
      n_checks++; if (HWDATA !== 64'h0123_4567_89AB_CDEF) $display("FAIL ws_hwdata%0d: got %h want 0123456789abcdef", i, HWDATA); else n_pass++;
      n_checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL ws_ready_rsp%0d: got %b/%b want 0/0", i, cmd_ready, rsp_valid); else n_pass++;
      tick();
    end
    HREADY = 1'b1;
    #1;
    n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h48 || rsp_valid !== 1'b0) $display("FAIL ws_release: got %h/%h/%b want 2/48/0", HTRANS, HADDR, rsp_valid); else n_pass++;
    tick();
    HRDATA = 64'h55;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h0 || rsp_err !== 1'b0) $display("FAIL ws_wr_rsp: got %b/%h/%b want 1/0/0", rsp_valid, rsp_rdata, rsp_err); else n_pass++;
    n_checks++; if (HTRANS !== 2'b00) $display("FAIL ws_idle: got %h want 0", HTRANS); else n_pass++;
    tick();
    HRDATA = 64'h0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h55) $display("FAIL ws_rd_rsp: got %b/%h want 1/55", rsp_valid, rsp_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_error();
    set_cmd(1'b0, 32'h2000, 3'd2, 4'b0001, 64'h0);
    tick();
    set_cmd(1'b0, 32'h2004, 3'd2, 4'b0001, 64'h0);
    tick();
    cmd_valid = 1'b0;
    HREADY = 1'b0;
    HRESP = 1'b1;
    #1;
    n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h2004) $display("FAIL err_first: got %h/%h want 2/2004", HTRANS, HADDR); else n_pass++;
    tick();
    HREADY = 1'b1;
    #1;
    n_checks++; if (HTRANS !== 2'b00) $display("FAIL err_cancel_idle: got %h want 0", HTRANS); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b0 || HADDR !== 32'h2004) $display("FAIL err_cancel_hold: got %b/%h want 0/2004", cmd_ready, HADDR); else n_pass++;
    tick();
    HRESP = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) $display("FAIL err_rsp: got %b/%b want 1/1", rsp_valid, rsp_err); else n_pass++;
    n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h2004) $display("FAIL err_reissue: got %h/%h want 2/2004", HTRANS, HADDR); else n_pass++;
    tick();
    HRDATA = 64'h77;
    n_checks++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) $display("FAIL err_reissue_once: got %h/%b want 0/0", HTRANS, rsp_valid); else n_pass++;
    tick();
    HRDATA = 64'h0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 64'h77) $display("FAIL err_second_rsp: got %b/%b/%h want 1/0/77", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    set_cmd(1'b0, 32'h3000, 3'd2, 4'b0001, 64'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    HREADY = 1'b0;
    #1;
    HRESETn = 1'b0;
    #1;
    n_checks++; if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWDATA !== 64'h0) $display("FAIL rmid_bus: got %h/%h/%h want 0/0/0", HTRANS, HADDR, HWDATA); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 64'h0) $display("FAIL rmid_ctl: got %b/%b/%h want 0/0/0", cmd_ready, rsp_valid, rsp_rdata); else n_pass++;
    tick();
    HREADY = 1'b1;
    HRESETn = 1'b1;
    tick();
    n_checks++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) $display("FAIL rmid_no_rsp: got %b/%h want 0/0", rsp_valid, HTRANS); else n_pass++;
    set_cmd(1'b1, 32'h3008, 3'd3, 4'b0011, 64'hCAFE);
    tick();
    cmd_valid = 1'b0;
    n_checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h3008 || HWRITE !== 1'b1) $display("FAIL rmid_wr_aph: got %h/%h/%b want 2/3008/1", HTRANS, HADDR, HWRITE); else n_pass++;
    tick();
    n_checks++; if (HWDATA !== 64'hCAFE) $display("FAIL rmid_wr_hwdata: got %h want cafe", HWDATA); else n_pass++;
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) $display("FAIL rmid_wr_rsp: got %b/%b want 1/0", rsp_valid, rsp_err); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
